// File: rtl/bomb_countdown.sv
// Purpose : game countdown timer. Counts START_SECS down to 0 in whole seconds,
//           freezes while paused, subtracts a penalty per wrong wire, flags expiry.
// Latency : time_left, sec_tick and state update on the edge after the input;
//           the mm:ss digits follow time_left one cycle later.
// Backpressure: none. start, penalty and pause are accepted every cycle.
// Ports   : clk/reset (sync, active-high); start/penalty are 1-cycle pulses;
//           pause is a level. time_left is binary seconds; min_bcd/sec_tens/sec_ones
//           are BCD digits; sec_tick pulses on each 1-second decrement;
//           running/warn/expired are status decodes.
module bomb_countdown #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned START_SECS   = 120,
  parameter int unsigned PENALTY_SECS = 10,
  parameter int unsigned WARN_SECS    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       penalty,
  output logic [9:0] time_left,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       running,
  output logic       warn,
  output logic       expired
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [9:0]       START_TL = 10'(START_SECS);
  localparam logic [10:0]      PEN_11   = 11'(PENALTY_SECS);
  localparam logic [9:0]       WARN_TL  = 10'(WARN_SECS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [9:0]       time_left_q, time_left_d;
  logic             sec_tick_q, sec_tick_d;
  logic [11:0]      digits_q, digits_d;

  // Working values for the countdown update.
  logic        advance;
  logic        wrap;
  logic [10:0] sub_amt;
  logic [10:0] diff;

  // Binary seconds (0..599) to {minutes, seconds tens, seconds ones} in BCD.
  // Threshold compares unroll into a small comparator ladder, no divider.
  function automatic logic [11:0] to_bcd(input logic [9:0] v);
    logic [3:0] m;
    logic [3:0] t;
    logic [9:0] r;
    logic [9:0] o;
    m = 4'd0;
    r = v;
    for (int i = 1; i <= 9; i++) begin
      if (v >= 10'(60 * i)) begin
        m = 4'(i);
        r = v - 10'(60 * i);
      end
    end
    t = 4'd0;
    o = r;
    for (int i = 1; i <= 5; i++) begin
      if (r >= 10'(10 * i)) begin
        t = 4'(i);
        o = r - 10'(10 * i);
      end
    end
    return {m, t, o[3:0]};
  endfunction

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      time_left_q <= '0;
      sec_tick_q  <= 1'b0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      time_left_q <= time_left_d;
      sec_tick_q  <= sec_tick_d;
      digits_q    <= digits_d;
    end
  end

  // Next state and countdown arithmetic.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    time_left_d = time_left_q;
    sec_tick_d  = 1'b0;
    advance     = 1'b0;
    wrap        = 1'b0;
    sub_amt     = '0;
    diff        = '0;
    digits_d    = to_bcd(time_left_q);

    if (start) begin
      // start wins over everything else, including a same-cycle penalty.
      time_left_d = START_TL;
      pre_d       = '0;
      state_d     = pause ? S_PAUSED : S_RUN;
    end else begin
      case (state_q)
        S_RUN, S_PAUSED: begin
          // The prescaler only moves in RUN with pause low; the cycle that
          // enters PAUSED and the cycle that leaves it both hold it.
          advance = (state_q == S_RUN) && !pause;
          wrap    = advance && (pre_q == PRE_MAX);
          if (advance) begin
            pre_d = wrap ? '0 : pre_q + PRE_W'(1);
          end
          sec_tick_d = wrap;

          // 11-bit subtract: bit 10 set means the result went below zero.
          sub_amt     = (penalty ? PEN_11 : 11'd0) + (wrap ? 11'd1 : 11'd0);
          diff        = {1'b0, time_left_q} - sub_amt;
          time_left_d = diff[10] ? 10'd0 : diff[9:0];

          if (state_q == S_RUN && pause) begin
            state_d = S_PAUSED;
          end else if (state_q == S_PAUSED && !pause) begin
            state_d = S_RUN;
          end

          if (time_left_d == 10'd0) begin
            state_d = S_EXPIRED;
            pre_d   = '0;
          end
        end
        default: begin
          // IDLE and EXPIRED wait for start; penalty and pause are ignored.
        end
      endcase
    end
  end

  // Status decode from registered state.
  always_comb begin
    time_left = time_left_q;
    sec_tick  = sec_tick_q;
    min_bcd   = digits_q[11:8];
    sec_tens  = digits_q[7:4];
    sec_ones  = digits_q[3:0];
    running   = (state_q == S_RUN);
    expired   = (state_q == S_EXPIRED);
    warn      = ((state_q == S_RUN) || (state_q == S_PAUSED)) &&
                (time_left_q != 10'd0) && (time_left_q <= WARN_TL);
  end

endmodule
